// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite bus bundle between a master and ahb_mem_slave.
// Signals: hsel/haddr/htrans/hwrite/hsize (address phase), hwdata (data phase),
//          hrdata/hready/hresp (slave response), slv_busy (external stall input).
interface ahb_mem_slave_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic                  hresp;
  logic                  slv_busy;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, slv_busy,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, slv_busy,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: byte-lane writes, programmable wait states, optional ERROR response.
// Latency: OKAY data phase WAIT_STATES+1 cycles minimum, ERROR data phase exactly 2 cycles.
// Backpressure: hready held low for WAIT_STATES cycles, then for every cycle slv_busy is 1.
// Ports: hclk, hresetn (async, active-low), bus (ahb_mem_slave_if.slave).
// Build option: define AHB_MEM_SLAVE_ERR_EN to build in the error checks and ERR1/ERR2 states;
// without it hresp is 0, word index wraps, misaligned offsets round down, oversize clamps.
module ahb_mem_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            hclk,
  input  logic            hresetn,
  ahb_mem_slave_if.slave  bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int OW = (LB > 0) ? LB : 1;
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [OW-1:0]   off_q, off_d;
  logic [2:0]      size_q, size_d;
  logic            write_q, write_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  hready;
  logic                  accept;
  logic                  acc_err;
  logic [ADDR_WIDTH-1:0] word_full;
  logic [OW-1:0]         off_raw;
  logic [OW-1:0]         size_mask;
  logic [2:0]            size_eff;
  logic [NB-1:0]         lane_we;
  logic                  mem_we;
  logic                  unused_htrans0;

  assign unused_htrans0 = bus.htrans[0];

  // Address-phase decode.
  assign word_full = bus.haddr >> LB;
  assign off_raw   = OW'(bus.haddr & ADDR_WIDTH'(NB - 1));
  assign size_eff  = (bus.hsize > 3'(LB)) ? 3'(LB) : bus.hsize;
  assign size_mask = OW'((1 << size_eff) - 1);
  assign accept    = hready && bus.hsel && bus.htrans[1];

`ifdef AHB_MEM_SLAVE_ERR_EN
  logic [ADDR_WIDTH:0] depth_ext;
  logic                hresp;
  assign depth_ext = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  assign acc_err   = (bus.hsize > 3'(LB)) || ((off_raw & size_mask) != '0) ||
                     ({1'b0, word_full} >= depth_ext);
  assign bus.hresp = hresp;
`else
  assign acc_err   = 1'b0;
  assign bus.hresp = 1'b0;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    hready  = 1'b1;
`ifdef AHB_MEM_SLAVE_ERR_EN
    hresp   = 1'b0;
`endif
    case (state_q)
      // slv_busy only matters once the fixed wait count has drained.
      ST_DATA: hready = (wcnt_q == 4'd0) && !bus.slv_busy;
`ifdef AHB_MEM_SLAVE_ERR_EN
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
`endif
      default: hready = 1'b1;
    endcase

    if (hready) begin
      if (accept) begin
        write_d = bus.hwrite;
        size_d  = size_eff;
        // Index wraps and offset rounds down; with error checks on, any case
        // where that would change the address is already an ERROR.
        idx_d   = IW'(32'(word_full) % 32'(MEM_DEPTH));
        off_d   = off_raw & ~size_mask;
        if (acc_err) begin
          state_d = ST_ERR1;
        end else begin
          state_d = ST_DATA;
          wcnt_d  = 4'(WAIT_STATES);
        end
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_DATA) begin
      if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
    end else begin
      // Only ERR1 stalls outside ST_DATA; htrans is ignored here.
      state_d = ST_ERR2;
    end
  end

  assign bus.hready = hready;

  always_comb begin
    lane_we = '0;
    for (int b = 0; b < NB; b++) begin
      lane_we[b] = (b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q));
    end
  end

  // Write lands on the edge that completes the data phase; reset forces
  // ST_IDLE so a pending write is dropped.
  assign mem_we = (state_q == ST_DATA) && hready && write_q;

  always_ff @(posedge hclk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (lane_we[b]) mem[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
      end
    end
  end

  assign bus.hrdata = ((state_q == ST_DATA) && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
module tb_ahb_mem_slave;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wdata;
    int          blo;
    int          bn;
  } op_t;

  typedef struct {
    logic [31:0] rdata;
    logic        resp;
    int          waits;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        use2 = 1'b0;
  logic        hsel = 1'b0;
  logic [11:0] haddr = '0;
  logic [1:0]  htrans = T_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [31:0] hwdata = '0;
  logic        slv_busy = 1'b0;

  int checks = 0;
  int errors = 0;

  op_t         stim_q[$];
  exp_t        exp_q[$];
  logic [31:0] mdl [2][256];

  always #5 hclk = ~hclk;

  ahb_mem_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus0 ();
  ahb_mem_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus2 ();

  assign bus0.hsel     = hsel & ~use2;
  assign bus2.hsel     = hsel & use2;
  assign bus0.haddr    = haddr;
  assign bus2.haddr    = haddr;
  assign bus0.htrans   = htrans;
  assign bus2.htrans   = htrans;
  assign bus0.hwrite   = hwrite;
  assign bus2.hwrite   = hwrite;
  assign bus0.hsize    = hsize;
  assign bus2.hsize    = hsize;
  assign bus0.hwdata   = hwdata;
  assign bus2.hwdata   = hwdata;
  assign bus0.slv_busy = slv_busy & ~use2;
  assign bus2.slv_busy = slv_busy & use2;

  wire        hready_m = use2 ? bus2.hready : bus0.hready;
  wire        hresp_m  = use2 ? bus2.hresp  : bus0.hresp;
  wire [31:0] hrdata_m = use2 ? bus2.hrdata : bus0.hrdata;

  ahb_mem_slave #(.WAIT_STATES(0)) u_dut0 (.hclk(hclk), .hresetn(hresetn), .bus(bus0.slave));
  ahb_mem_slave #(.WAIT_STATES(2)) u_dut2 (.hclk(hclk), .hresetn(hresetn), .bus(bus2.slave));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Queue one transfer on the currently selected slave and record its expected outcome.
  task automatic push_op(input bit wr, input logic [11:0] a, input logic [2:0] sz,
                         input logic [1:0] tr, input logic [31:0] val,
                         input int blo = 0, input int bn = 0);
    int m = use2 ? 1 : 0;
    int ws = use2 ? 2 : 0;
    int esz, off, idx, c;
    bit err = 1'b0;
    logic [31:0] mask;
    op_t o;
    exp_t e;
    off = int'(a[1:0]);
    idx = int'(a >> 2);
`ifdef AHB_MEM_SLAVE_ERR_EN
    esz = int'(sz);
    err = (sz > 3'd2) || ((off % (1 << esz)) != 0) || (idx >= 256);
`else
    esz = (sz > 3'd2) ? 2 : int'(sz);
    off = off - (off % (1 << esz));
    idx = idx % 256;
`endif
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      if (b >= off && b < off + (1 << esz)) mask[8*b +: 8] = 8'hFF;
    end
    o.wr = wr; o.addr = a; o.size = sz; o.trans = tr; o.blo = blo; o.bn = bn;
    o.wdata = ($urandom() & ~mask) | ((val << (8 * off)) & mask);
    e.resp = err;
    e.rdata = '0;
    if (err) begin
      e.waits = 1;
    end else begin
      if (wr) mdl[m][idx] = (mdl[m][idx] & ~mask) | (o.wdata & mask);
      else    e.rdata = mdl[m][idx];
      c = 0;
      while (c < ws || (c >= blo && c < blo + bn)) c++;
      e.waits = c;
    end
    stim_q.push_back(o);
    exp_q.push_back(e);
  endtask

  // Pipelined master: address of the next op overlaps the data phase of the current one.
  task automatic run_q(input string tag);
    op_t  ap, dp;
    exp_t e;
    bit   ap_vld = 0, dp_vld = 0, adv = 1;
    int   dp_cyc = 0, n = 0;
    while ((stim_q.size() > 0 || ap_vld || dp_vld) && n < 1000) begin
      @(negedge hclk);
      n++;
      if (adv) begin
        dp = ap; dp_vld = ap_vld; dp_cyc = 0;
        hwdata = (dp_vld && dp.wr) ? dp.wdata : $urandom();
        if (stim_q.size() > 0) begin
          ap = stim_q.pop_front(); ap_vld = 1;
          hsel = 1'b1; haddr = ap.addr; htrans = ap.trans; hwrite = ap.wr; hsize = ap.size;
        end else begin
          ap_vld = 0;
          hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0;
        end
      end
      slv_busy = dp_vld && dp_cyc >= dp.blo && dp_cyc < dp.blo + dp.bn;
      #1;
      adv = hready_m;
      if (adv) begin
        if (dp_vld) begin
          e = exp_q.pop_front();
          chk({tag, "_rdata"}, hrdata_m, e.rdata);
          chk({tag, "_hresp"}, 32'(hresp_m), 32'(e.resp));
          chk({tag, "_waits"}, 32'(dp_cyc), 32'(e.waits));
        end
      end else begin
        dp_cyc++;
      end
    end
    slv_busy = 1'b0;
    chk({tag, "_done"}, 32'(stim_q.size() == 0 && !ap_vld && !dp_vld), 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_hready0"}, 32'(bus0.hready), 32'd1);
    chk({tag, "_hresp0"},  32'(bus0.hresp),  32'd0);
    chk({tag, "_hrdata0"}, bus0.hrdata,      32'd0);
    chk({tag, "_hready2"}, 32'(bus2.hready), 32'd1);
    chk({tag, "_hresp2"},  32'(bus2.hresp),  32'd0);
    chk({tag, "_hrdata2"}, bus2.hrdata,      32'd0);
  endtask

  initial begin
    repeat (3) @(negedge hclk);
    chk_reset_outs("reset");
    hresetn = 1'b1;

    // Zero-wait slave: word round trip and byte/halfword lanes.
    use2 = 1'b0;
    push_op(1, 12'h010, 3'd2, T_NSEQ, 32'hDEADBEEF);
    push_op(0, 12'h010, 3'd2, T_NSEQ, 32'h0);
    push_op(1, 12'h012, 3'd0, T_NSEQ, 32'h5A);
    push_op(0, 12'h010, 3'd2, T_NSEQ, 32'h0);
    push_op(1, 12'h010, 3'd1, T_NSEQ, 32'h1234);
    push_op(0, 12'h010, 3'd2, T_NSEQ, 32'h0);
    push_op(1, 12'h014, 3'd2, T_NSEQ, 32'h01020304);
    push_op(1, 12'h016, 3'd1, T_NSEQ, 32'hABCD);
    push_op(1, 12'h015, 3'd0, T_NSEQ, 32'h77);
    push_op(0, 12'h014, 3'd2, T_NSEQ, 32'h0);
    run_q("lanes");

    // Back-to-back SEQ burst writes then burst reads.
    for (int i = 0; i < 4; i++)
      push_op(1, 12'h020 + 12'(4 * i), 3'd2, (i == 0) ? T_NSEQ : T_SEQ, 32'(i + 1));
    for (int i = 0; i < 4; i++)
      push_op(0, 12'h020 + 12'(4 * i), 3'd2, (i == 0) ? T_NSEQ : T_SEQ, 32'h0);
    run_q("burst");

`ifdef AHB_MEM_SLAVE_ERR_EN
    push_op(1, 12'h000, 3'd2, T_NSEQ, 32'hCAFEF00D);
    push_op(1, 12'h040, 3'd2, T_NSEQ, 32'h600DD00D);
    push_op(1, 12'h401, 3'd2, T_NSEQ, 32'h11111111);
    push_op(1, 12'h400, 3'd2, T_NSEQ, 32'h22222222);
    push_op(1, 12'h041, 3'd2, T_NSEQ, 32'h33333333);
    push_op(1, 12'h040, 3'd3, T_NSEQ, 32'h44444444);
    push_op(0, 12'h400, 3'd2, T_NSEQ, 32'h0);
    push_op(0, 12'h000, 3'd2, T_NSEQ, 32'h0);
    push_op(0, 12'h040, 3'd2, T_NSEQ, 32'h0);
    run_q("err");
`else
    push_op(1, 12'h000, 3'd2, T_NSEQ, 32'hCAFEF00D);
    push_op(1, 12'h400, 3'd2, T_NSEQ, 32'h0BADCAFE);
    push_op(0, 12'h000, 3'd2, T_NSEQ, 32'h0);
    push_op(1, 12'h041, 3'd2, T_NSEQ, 32'h13579BDF);
    push_op(0, 12'h040, 3'd2, T_NSEQ, 32'h0);
    push_op(1, 12'h050, 3'd3, T_NSEQ, 32'h2468ACE0);
    push_op(1, 12'h053, 3'd1, T_NSEQ, 32'h9876);
    push_op(0, 12'h050, 3'd2, T_NSEQ, 32'h0);
    run_q("wrap");
`endif

    // Two-wait-state slave: fixed waits, then slv_busy honoured only after they drain.
    use2 = 1'b1;
    push_op(1, 12'h010, 3'd2, T_NSEQ, 32'h0F0F0F0F);
    push_op(0, 12'h010, 3'd2, T_NSEQ, 32'h0, 2, 1);
    push_op(0, 12'h010, 3'd2, T_NSEQ, 32'h0, 0, 1);
    push_op(1, 12'h011, 3'd0, T_NSEQ, 32'hC3, 2, 3);
    push_op(0, 12'h010, 3'd2, T_NSEQ, 32'h0, 1, 4);
    push_op(1, 12'h030, 3'd2, T_NSEQ, 32'h11111111);
    run_q("wait");

    // Reset during a write data phase stalled by slv_busy.
    @(negedge hclk);
    hsel = 1'b1; haddr = 12'h030; htrans = T_NSEQ; hwrite = 1'b1; hsize = 3'd2;
    @(negedge hclk);
    hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0; hwdata = 32'h22222222; slv_busy = 1'b1;
    repeat (4) @(negedge hclk);
    #1;
    chk("rstmid_stall", 32'(hready_m), 32'd0);
    hresetn = 1'b0;
    #1;
    chk_reset_outs("rstmid");
    @(negedge hclk);
    hresetn = 1'b1;
    slv_busy = 1'b0;
    push_op(0, 12'h030, 3'd2, T_NSEQ, 32'h0);
    run_q("rstmid_read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_mem_slave.md
# ahb_mem_slave

AHB-Lite memory slave with byte-lane writes, programmable wait states and an error response. It replaces the single-size, zero-wait slave on the example AHB fabric. It sits behind the decoder (hsel) and is driven directly by the bench master. It backs a `MEM_DEPTH`-word internal array and supports NONSEQ and SEQ transfers of any size up to `DATA_WIDTH`.

## Interface
- `ADDR_WIDTH`, 12, byte address width; must cover `MEM_DEPTH*DATA_WIDTH/8` bytes.
- `DATA_WIDTH`, 32, bus width; one of 8/16/32/64.
- `MEM_DEPTH`, 256, number of `DATA_WIDTH` words.
- `WAIT_STATES`, 0, fixed wait cycles inserted in every OKAY data phase (0–15).
- `hclk` in 1: clock, rising edge.
- `hresetn` in 1: reset, asynchronous, active-low.
- `hsel` in 1: slave select, address phase.
- `haddr` in `ADDR_WIDTH`: byte address.
- `htrans` in 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: transfer size, 2^hsize bytes.
- `hwdata` in `DATA_WIDTH`: write data, data phase.
- `hrdata` out `DATA_WIDTH`: read data; zero outside a completing read data phase.
- `hready` out 1: transfer done / slave ready.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.
- `slv_busy` in 1: external stall; holds `hready` low during an OKAY data phase.

## Operation
- **Definitions.** `NB = DATA_WIDTH/8`, `LB = log2(NB)`. Byte offset is `haddr[LB-1:0]`. Word index is `haddr >> LB`.
- **Accept.** An address phase is accepted on a rising edge when `hready` is 1, `hsel` is 1 and `htrans[1]` is 1. The edge registers `haddr`, `hwrite` and `hsize`.
- **Non-accepted cycles.** IDLE and BUSY transfers, and unselected cycles, are not accepted. The slave goes to (or stays in) ST_IDLE.
- **Error check at accept.** ERROR results if any of the following holds:
  - `hsize > LB`;
  - offset is not a multiple of 2^hsize;
  - word index ≥ `MEM_DEPTH`.
- **FSM states:**
  - ST_IDLE: `hready`=1, `hresp`=0.
  - ST_DATA: `hresp`=0; `hready` = (`wcnt`==0) && !`slv_busy`.
  - ST_ERR1: `hready`=0, `hresp`=1.
  - ST_ERR2: `hready`=1, `hresp`=1.
- **Transitions:**
  - Any state with `hready`=1: an accepted OKAY transfer goes to ST_DATA with `wcnt` = `WAIT_STATES`; an accepted ERROR transfer goes to ST_ERR1; otherwise go to ST_IDLE.
  - ST_DATA with `hready`=0: `wcnt` decrements if nonzero; stay in ST_DATA.
  - ST_ERR1 always goes to ST_ERR2.
- **Write.** Occurs on the edge ending ST_DATA with `hready`=1 and the registered `hwrite`=1. Only lanes offset..offset+2^hsize−1 of the word are updated from the same lanes of `hwdata`. Other bytes are unchanged.
- **Read.** `hrdata` is the full word at the registered index (all lanes, combinational from the array) while in ST_DATA with registered `hwrite`=0. Otherwise `hrdata` = 0.
- **Read-after-write.** A read following a write back-to-back returns the newly written data.
- **Errored transfers.** Never modify memory. `hrdata` = 0.
- **Wait-state order.** `slv_busy` is sampled only after `wcnt` reaches 0. Wait cycles = `WAIT_STATES` + cycles with `slv_busy`=1 thereafter.

## Timing
- **Reset values.** `hready`=1, `hresp`=0, `hrdata`=0. State ST_IDLE, `wcnt`=0. Memory contents are undefined (not reset).
- **Reset mid-transfer.** Asynchronous return to reset values. The pending write is dropped.
- **Latency.** The OKAY data phase lasts `WAIT_STATES`+1 cycles minimum. The ERROR data phase lasts exactly 2 cycles.
- **Pipelining.** The address phase of the next transfer overlaps the last data-phase cycle, so back-to-back transfers run without idle cycles.
- **Signals after an ERROR.** `htrans` during ST_ERR1 is ignored. A new transfer may be accepted in ST_ERR2.

## Configuration
- `AHB_MEM_SLAVE_ERR_EN` defined: error checks and the ST_ERR1/ST_ERR2 states are built in, as described above.
- Not defined:
  - `hresp` is tied to 0 and no ERROR responses occur.
  - Word index wraps modulo `MEM_DEPTH`.
  - Misaligned transfers use `hsize`-aligned lanes (offset rounded down).
  - `hsize > LB` is treated as `LB`.

## Test plan
- **Reset then word round trip.** Reset, check `hready`=1, `hresp`=0, `hrdata`=0. NONSEQ word write 0xDEADBEEF to 0x010, then read 0x010 → `hrdata`=0xDEADBEEF in the cycle `hready`=1.
- **Byte lane write.** After the word above, byte write 0x5A to 0x012 (`hsize`=0). Read 0x010 → 0xDE5ABEEF. Halfword write 0x1234 to 0x010 → read 0xDE5A1234.
- **Wait states.** `WAIT_STATES`=2 with `slv_busy` pulsed 1 cycle after `wcnt` hits 0. Read data phase → `hready` low exactly 3 cycles, data valid on the 4th.
- **Back-to-back SEQ burst.** With `WAIT_STATES`=0, 4-beat SEQ writes to 0x020..0x02C of 1,2,3,4, then a burst read → 1,2,3,4 on consecutive cycles, `hready` always 1.
- **Errors (ERR_EN).** Word access to 0x401 (misaligned) and to word index 256 → ERR1 (`hready`=0, `hresp`=1) then ERR2 (`hready`=1, `hresp`=1). Memory is unchanged.
- **Reset mid-write.** Deassert `hresetn` during a write data phase held by `slv_busy`. Outputs return to reset values, and the target word keeps its old value.
